// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types for the VGARAM port-B arbiter.
// Holds the FSM state encoding, requester IDs, tie-break policy and
// default RAM geometry.
package ram_arb_pkg;

    localparam int RAM_ADDR_W = 15;
    localparam int RAM_DATA_W = 16;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_CORE = 2'd1,
        ARB_IO   = 2'd2
    } arb_state_e;

    typedef enum logic {
        REQ_CORE = 1'b0,
        REQ_IO   = 1'b1
    } req_id_e;

    typedef enum logic {
        POL_FIXED = 1'b0,
        POL_RR    = 1'b1
    } arb_policy_e;

    function automatic req_id_e other_req(input req_id_e id);
        return (id == REQ_CORE) ? REQ_IO : REQ_CORE;
    endfunction

endpackage

// File: rtl/arb_pick2.sv
// arb_pick2: combinational two-way picker for the port-B arbiter.
// Build option: RAM_ARB_ROUND_ROBIN_EN enables the round-robin tie-break
// (the requester that did not win last time takes the tie). Without it the
// Core always takes a tie and the last_winner/policy inputs have no effect.
module arb_pick2
    import ram_arb_pkg::*;
(
    input  logic [1:0]  eligible_i,     // bit 0 = Core, bit 1 = IO
    input  req_id_e     last_winner_i,
    input  arb_policy_e policy_i,
    output req_id_e     winner_o,
    output logic        valid_o
);

`ifdef RAM_ARB_ROUND_ROBIN_EN
    localparam bit RR_BUILT = 1'b1;
`else
    localparam bit RR_BUILT = 1'b0;
`endif

    // Pick the single eligible requester, or resolve a tie by policy.
    always_comb begin
        winner_o = REQ_CORE;
        valid_o  = |eligible_i;
        case (eligible_i)
            2'b01:   winner_o = REQ_CORE;
            2'b10:   winner_o = REQ_IO;
            2'b11: begin
                if (RR_BUILT && (policy_i == POL_RR)) begin
                    winner_o = other_req(last_winner_i);
                end else begin
                    winner_o = REQ_CORE;
                end
            end
            default: winner_o = REQ_CORE;
        endcase
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares VGARAM port B between the Core and the
// IOController. Port-B controls are registered; read data returns one
// cycle after a read grant with a per-requester valid strobe.
// Build option: RAM_ARB_ROUND_ROBIN_EN selects round-robin tie-break and
// builds the last_winner register; otherwise the Core wins every tie.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = RAM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_gnt,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,

    input  logic              io_req,
    input  logic              io_we,
    input  logic [ADDR_W-1:0] io_addr,
    input  logic [DATA_W-1:0] io_wdata,
    output logic              io_gnt,
    output logic              io_rvalid,
    output logic [DATA_W-1:0] io_rdata,

    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] data_to_ram,
    output logic              web,
    input  logic [DATA_W-1:0] data_from_ram
);

    arb_state_e        state_q, state_d;
    logic              core_gnt_q, core_gnt_d;
    logic              io_gnt_q, io_gnt_d;
    logic              web_q, web_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              core_rvalid_q, core_rvalid_d;
    logic              io_rvalid_q, io_rvalid_d;

    logic [1:0]        eligible;
    req_id_e           winner;
    logic              win_valid;
    req_id_e           last_winner;
    arb_policy_e       policy;

    // A requester granted this cycle still shows req at the edge; mask it
    // so it cannot be granted twice for one request.
    assign eligible[0] = core_req & (state_q != ARB_CORE);
    assign eligible[1] = io_req   & (state_q != ARB_IO);

`ifdef RAM_ARB_ROUND_ROBIN_EN
    req_id_e last_winner_q, last_winner_d;

    // Remember who was granted most recently for the next tie.
    always_comb begin
        last_winner_d = last_winner_q;
        if (state_d == ARB_CORE) begin
            last_winner_d = REQ_CORE;
        end else if (state_d == ARB_IO) begin
            last_winner_d = REQ_IO;
        end
    end

    // last_winner register; resets to IO so the Core takes the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_winner_q <= REQ_IO;
        end else begin
            last_winner_q <= last_winner_d;
        end
    end

    assign last_winner = last_winner_q;
    assign policy      = POL_RR;
`else
    assign last_winner = REQ_IO;
    assign policy      = POL_FIXED;
`endif

    arb_pick2 u_pick (
        .eligible_i    (eligible),
        .last_winner_i (last_winner),
        .policy_i      (policy),
        .winner_o      (winner),
        .valid_o       (win_valid)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: whoever the picker selects, idle when nobody is eligible.
    always_comb begin
        state_d = ARB_IDLE;
        if (win_valid) begin
            state_d = (winner == REQ_CORE) ? ARB_CORE : ARB_IO;
        end
    end

    // Output next-values: load the winner's access, hold address/data in idle,
    // and flag a read return for whoever was granted a read this cycle.
    always_comb begin
        core_gnt_d = (state_d == ARB_CORE);
        io_gnt_d   = (state_d == ARB_IO);
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        web_d      = 1'b0;
        case (state_d)
            ARB_CORE: begin
                addr_d  = core_addr;
                wdata_d = core_wdata;
                web_d   = core_we;
            end
            ARB_IO: begin
                addr_d  = io_addr;
                wdata_d = io_wdata;
                web_d   = io_we;
            end
            default: begin
            end
        endcase
        core_rvalid_d = (state_q == ARB_CORE) & ~web_q;
        io_rvalid_d   = (state_q == ARB_IO)   & ~web_q;
    end

    // Output registers; reset drops any read return still in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            core_gnt_q    <= 1'b0;
            io_gnt_q      <= 1'b0;
            web_q         <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            core_rvalid_q <= 1'b0;
            io_rvalid_q   <= 1'b0;
        end else begin
            core_gnt_q    <= core_gnt_d;
            io_gnt_q      <= io_gnt_d;
            web_q         <= web_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            core_rvalid_q <= core_rvalid_d;
            io_rvalid_q   <= io_rvalid_d;
        end
    end

    assign core_gnt    = core_gnt_q;
    assign io_gnt      = io_gnt_q;
    assign web         = web_q;
    assign ram_address = addr_q;
    assign data_to_ram = wdata_q;
    assign core_rvalid = core_rvalid_q;
    assign io_rvalid   = io_rvalid_q;
    assign core_rdata  = data_from_ram;
    assign io_rdata    = data_from_ram;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed scenarios plus randomized traffic from two
// requesters, checked cycle by cycle against a transaction-level model
// (shadow memory, grant rules, expected read returns).
`timescale 1ns/1ps
module tb_ram_port_arbiter;

    localparam int AW = 15;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;

    logic          c_pend = 1'b0, c_we = 1'b0;
    logic [AW-1:0] c_addr = '0;
    logic [DW-1:0] c_wdata = '0;
    logic          i_pend = 1'b0, i_we = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic [DW-1:0] i_wdata = '0;

    logic          core_gnt, core_rvalid, io_gnt, io_rvalid, web;
    logic [DW-1:0] core_rdata, io_rdata, data_to_ram;
    logic [DW-1:0] data_from_ram;
    logic [AW-1:0] ram_address;

    always #5 clk = ~clk;

    ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk           (clk),
        .rst           (rst),
        .core_req      (c_pend),
        .core_we       (c_we),
        .core_addr     (c_addr),
        .core_wdata    (c_wdata),
        .core_gnt      (core_gnt),
        .core_rvalid   (core_rvalid),
        .core_rdata    (core_rdata),
        .io_req        (i_pend),
        .io_we         (i_we),
        .io_addr       (i_addr),
        .io_wdata      (i_wdata),
        .io_gnt        (io_gnt),
        .io_rvalid     (io_rvalid),
        .io_rdata      (io_rdata),
        .ram_address   (ram_address),
        .data_to_ram   (data_to_ram),
        .web           (web),
        .data_from_ram (data_from_ram)
    );

    // Synchronous VGARAM port B with a bench-side preload path.
    logic [DW-1:0] ram [0:(1<<AW)-1];
    logic          pre_en = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [DW-1:0] pre_data = '0;

    always @(posedge clk) begin
        if (pre_en) ram[pre_addr] <= pre_data;
        else if (web) ram[ram_address] <= data_to_ram;
        data_from_ram <= ram[ram_address];
    end

    // Reference model state.
    logic [DW-1:0] shadow [0:(1<<AW)-1];
    bit            m_cg, m_ig, m_web, m_crv, m_irv, m_last_io;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_crd, m_ird, nx_crd, nx_ird;

    int n_chk = 0, n_pass = 0, cyc = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic core_issue(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        c_we = we; c_addr = a; c_wdata = d; c_pend = 1'b1;
    endtask

    task automatic io_issue(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        i_we = we; i_addr = a; i_wdata = d; i_pend = 1'b1;
    endtask

    // Apply one clock edge to the model using the inputs held before it.
    task automatic model_edge();
        bit ce, ie, pick_core, pick_io, tie_core;
        if (rst) begin
            m_cg = 0; m_ig = 0; m_web = 0; m_addr = '0; m_wdata = '0;
            m_crv = 0; m_irv = 0; m_last_io = 1;
            return;
        end
        m_crv = m_cg && !m_web;
        m_irv = m_ig && !m_web;
        m_crd = nx_crd;
        m_ird = nx_ird;
        ce = c_pend && !m_cg;
        ie = i_pend && !m_ig;
`ifdef RAM_ARB_ROUND_ROBIN_EN
        tie_core = m_last_io;
`else
        tie_core = 1;
`endif
        pick_core = ce && (!ie || tie_core);
        pick_io   = ie && !pick_core;
        m_cg = pick_core;
        m_ig = pick_io;
        if (pick_core) begin
            m_addr = c_addr; m_wdata = c_wdata; m_web = c_we; m_last_io = 0;
            if (c_we) shadow[c_addr] = c_wdata;
            else nx_crd = shadow[c_addr];
        end else if (pick_io) begin
            m_addr = i_addr; m_wdata = i_wdata; m_web = i_we; m_last_io = 1;
            if (i_we) shadow[i_addr] = i_wdata;
            else nx_ird = shadow[i_addr];
        end else begin
            m_web = 0;
        end
    endtask

    task automatic compare_all();
        chk("core_gnt", 32'(core_gnt), 32'(m_cg));
        chk("io_gnt", 32'(io_gnt), 32'(m_ig));
        chk("web", 32'(web), 32'(m_web));
        chk("ram_address", 32'(ram_address), 32'(m_addr));
        chk("data_to_ram", 32'(data_to_ram), 32'(m_wdata));
        chk("core_rvalid", 32'(core_rvalid), 32'(m_crv));
        chk("io_rvalid", 32'(io_rvalid), 32'(m_irv));
        if (m_crv) chk("core_rdata", 32'(core_rdata), 32'(m_crd));
        if (m_irv) chk("io_rdata", 32'(io_rdata), 32'(m_ird));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        compare_all();
        if (core_gnt === 1'b1) c_pend = 1'b0;
        if (io_gnt === 1'b1) i_pend = 1'b0;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pre_addr = a; pre_data = d; pre_en = 1'b1;
        shadow[a] = d;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 7) == 0) return 15'h7FFF;
        return AW'($urandom_range(0, 31));
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int c_n, i_n, first, last, dbl;
        for (int a = 0; a < 32; a++) preload(AW'(a), DW'($urandom));
        preload(15'h7FFF, DW'($urandom));
        preload(15'h0010, 16'hBEEF);
        pre_en = 1'b0;

        // Reset values
        step(); step();
        chk("rst_core_gnt", 32'(core_gnt), 0);
        chk("rst_web", 32'(web), 0);
        chk("rst_addr", 32'(ram_address), 0);
        rst = 1'b0;

        // Uncontended Core read of 0x0010
        core_issue(0, 15'h0010, '0);
        step();
        chk("t1_gnt", 32'(core_gnt), 1);
        chk("t1_addr", 32'(ram_address), 32'h10);
        chk("t1_web", 32'(web), 0);
        step();
        chk("t1_rvalid", 32'(core_rvalid), 1);
        chk("t1_rdata", 32'(core_rdata), 32'hBEEF);
        chk("t1_io_rvalid", 32'(io_rvalid), 0);

        // IO write then Core read-back of 0x7FFF
        io_issue(1, 15'h7FFF, 16'h1234);
        step();
        chk("t2_gnt", 32'(io_gnt), 1);
        chk("t2_web", 32'(web), 1);
        chk("t2_wdata", 32'(data_to_ram), 32'h1234);
        step();
        chk("t2_no_rvalid", 32'(io_rvalid), 0);
        core_issue(0, 15'h7FFF, '0);
        step(); step();
        chk("t2_rb_rvalid", 32'(core_rvalid), 1);
        chk("t2_rb_rdata", 32'(core_rdata), 32'h1234);

        // Simultaneous requests right after reset
        rst = 1'b1; step(); rst = 1'b0;
        core_issue(0, 15'h0010, '0);
        io_issue(0, 15'h7FFF, '0);
        step();
        chk("t3_core_first", 32'(core_gnt), 1);
        chk("t3_io_waits", 32'(io_gnt), 0);
        step();
        chk("t3_io_next", 32'(io_gnt), 1);
        chk("t3_core_rd", 32'(core_rdata), 32'hBEEF);
        step();
        chk("t3_io_rvalid", 32'(io_rvalid), 1);
        chk("t3_io_rd", 32'(io_rdata), 32'h1234);
        step();

        // Both requesters hammering: grants must alternate, 8 each
        c_n = 0; i_n = 0; first = -1; last = -1; dbl = 0;
        core_issue(bit'($urandom_range(0, 1)), rand_addr(), DW'($urandom));
        io_issue(bit'($urandom_range(0, 1)), rand_addr(), DW'($urandom));
        for (int k = 0; k < 40 && (c_n < 8 || i_n < 8); k++) begin
            step();
            if (core_gnt === 1'b1) c_n++;
            if (io_gnt === 1'b1) i_n++;
            if (core_gnt === 1'b1 && io_gnt === 1'b1) dbl++;
            if (core_gnt === 1'b1 || io_gnt === 1'b1) begin
                if (first < 0) first = cyc;
                last = cyc;
            end
            if (!c_pend && c_n < 8) core_issue(bit'($urandom_range(0, 1)), rand_addr(), DW'($urandom));
            if (!i_pend && i_n < 8) io_issue(bit'($urandom_range(0, 1)), rand_addr(), DW'($urandom));
        end
        chk("alt_core_cnt", c_n, 8);
        chk("alt_io_cnt", i_n, 8);
        chk("alt_span", last - first + 1, 16);
        chk("alt_double", dbl, 0);
        step(); step();

        // Read granted in the cycle that ends on a reset edge
        core_issue(0, 15'h0010, '0);
        step();
        chk("t5_gnt", 32'(core_gnt), 1);
        rst = 1'b1; step(); rst = 1'b0;
        chk("t5_rvalid", 32'(core_rvalid), 0);
        chk("t5_gnt_rst", 32'(core_gnt), 0);
        chk("t5_addr_rst", 32'(ram_address), 0);
        chk("t5_data_rst", 32'(data_to_ram), 0);
        step();
        chk("t5_rvalid_late", 32'(core_rvalid), 0);

        // Write granted in the cycle that ends on a reset edge still lands
        io_issue(1, 15'h0003, 16'h5A5A);
        step();
        chk("t6_gnt", 32'(io_gnt), 1);
        rst = 1'b1; step(); rst = 1'b0;
        chk("t6_ram", 32'(ram[3]), 32'h5A5A);
        core_issue(0, 15'h0003, '0);
        step(); step();
        chk("t6_rb", 32'(core_rdata), 32'h5A5A);

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            if (!c_pend && $urandom_range(0, 99) < 60)
                core_issue(bit'($urandom_range(0, 1)), rand_addr(), DW'($urandom));
            if (!i_pend && $urandom_range(0, 99) < 60)
                io_issue(bit'($urandom_range(0, 1)), rand_addr(), DW'($urandom));
            step();
        end
        for (int k = 0; k < 4; k++) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Shares port B of the dual-port VGARAM (15-bit word address, 16-bit data) between the Core and the IOController. Port A stays dedicated to the VGA controller. The block accepts a request/grant handshake from each requester and drives port B with registered outputs. It also returns read data with fixed latency and a per-requester valid strobe, so mouse state can be stored into memory-mapped RAM while the Core runs.

## Interface
Parameters:
- ADDR_W, 15, RAM word-address width
- DATA_W, 16, RAM data width

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- core_req  in  1  Core access request; held until core_gnt
- core_we  in  1  1 = write, 0 = read; stable while core_req
- core_addr  in  ADDR_W  Core word address; stable while core_req
- core_wdata  in  DATA_W  Core write data; stable while core_req
- core_gnt  out  1  one-cycle grant; access issued to RAM this cycle
- core_rvalid  out  1  one-cycle strobe; core_rdata valid
- core_rdata  out  DATA_W  read data, passed through from data_from_ram
- io_req, io_we, io_addr, io_wdata, io_gnt, io_rvalid, io_rdata: same as core_* for the IOController
- ram_address  out  ADDR_W  port B address (registered)
- data_to_ram  out  DATA_W  port B write data (registered)
- web  out  1  port B write enable (registered)
- data_from_ram  in  DATA_W  port B read data; synchronous RAM, valid one cycle after the address

## Operation
- FSM states: IDLE (no access this cycle), CORE (Core access on port B this cycle), IO (IO access on port B this cycle).
- At every edge, the next state is chosen from the eligible requests.
  - Eligible: req is high and the requester was not granted in the current cycle. A requester sees gnt at the edge and drops req after it, so this mask prevents a double grant.
  - No eligible request → IDLE.
  - One eligible request → that requester's state.
  - Both eligible → the winner is set by the priority policy (see Configuration).
- Entering CORE/IO registers the requester's addr, wdata and we onto ram_address, data_to_ram and web, and asserts that requester's gnt.
- web = we & granted. In IDLE, web = 0; ram_address and data_to_ram hold their last values.
- rvalid for a requester is registered and is high one cycle after a read grant to that requester. Writes never produce rvalid.
- rdata for both requesters is data_from_ram, unmodified. It is meaningful only while the matching rvalid is high.
- Throughput:
  - Port B can carry one access per cycle when the requesters alternate.
  - A single requester gets at most one access every two cycles.
- Reset values:
  - State IDLE.
  - core_gnt, io_gnt, core_rvalid, io_rvalid, web = 0.
  - ram_address and data_to_ram = 0.
  - last_winner = IO, so the Core wins the first tie.
- Reset mid-operation:
  - A write whose gnt cycle ends on the reset edge completes, because the RAM samples web at that edge.
  - A pending rvalid is dropped.
  - Requesters must reissue any read whose rvalid was lost.

## Timing
- Uncontended read: req high in cycle 0 → gnt and ram_address in cycle 1 → rvalid and rdata in cycle 2.
- Uncontended write: req in cycle 0 → gnt and web=1 in cycle 1 → RAM updated at the end of cycle 1.
- A loser of a tie keeps req high and is granted in the next cycle. Worst-case wait is 2 cycles after req with round-robin.
- All outputs come from flops except core_rdata and io_rdata, which are combinational pass-throughs.

## Configuration
- RAM_ARB_ROUND_ROBIN_EN
  - Defined: on a tie, the winner is the requester that is not last_winner. last_winner updates on every grant.
  - Undefined: fixed priority, Core always wins ties. last_winner is not built. The IO requester can starve only if the Core requests on every eligible cycle; by the two-cycle rule, IO is granted at least every other cycle.

## Structure
- Package ram_arb_pkg holds:
  - State encodings ARB_IDLE, ARB_CORE, ARB_IO (2-bit).
  - Requester IDs REQ_CORE = 0, REQ_IO = 1.
  - Defaults for ADDR_W and DATA_W.
- One sub-module, arb_pick2: combinational two-way picker. Inputs: eligible vector, last_winner, policy. Output: winner ID and a valid bit. It contains the RAM_ARB_ROUND_ROBIN_EN logic.
- The FSM, output registers and rvalid pipeline live in ram_port_arbiter.

## Test plan
- Reset then Core read of 0x0010 holding 0xBEEF, no IO activity → core_gnt in cycle 1, ram_address=0x0010, web=0; core_rvalid=1 with core_rdata=0xBEEF in cycle 2; io_rvalid stays 0.
- IO write 0x1234 to 0x7FFF → io_gnt in cycle 1 with web=1 and data_to_ram=0x1234. A following Core read of 0x7FFF returns 0x1234.
- Both requesters raise req in the same cycle after reset → Core is granted first, IO in the next cycle. Both rvalids appear in consecutive cycles with the correct data each.
- Both requesters hold req continuously for 8 accesses each → grants alternate every cycle, with exactly 8 gnts per requester and no double grant. Run with RAM_ARB_ROUND_ROBIN_EN both defined and undefined.
- Core read granted in cycle N with rst=1 in cycle N+1 → core_rvalid stays 0; all outputs hold reset values in cycle N+2.
- IO write granted in the cycle that ends on the rst edge → the RAM location holds the new value after reset.
